// File: rtl/fill_drain_if.sv
// Fill-drain port bundle: Fill FIFO read port plus the AXI4 AW/W/B write channels.
// master = the fill_drain block, slave = the FIFO/DRAM side.
interface fill_drain_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                             fill_fifo_empty_i;
    logic                             fill_fifo_rden_o;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_fifo_data_i;

    logic [ID_WIDTH-1:0]     awid_o;
    logic [ADDR_WIDTH-1:0]   awaddr_o;
    logic [7:0]              awlen_o;
    logic [2:0]              awsize_o;
    logic [1:0]              awburst_o;
    logic                    awvalid_o;
    logic                    awready_i;

    logic [DATA_WIDTH-1:0]   wdata_o;
    logic [DATA_WIDTH/8-1:0] wstrb_o;
    logic                    wlast_o;
    logic                    wvalid_o;
    logic                    wready_i;

    logic [ID_WIDTH-1:0]     bid_i;
    logic [1:0]              bresp_i;
    logic                    bvalid_i;
    logic                    bready_o;

    logic                    busy_o;
    logic                    err_o;

    modport master (
        input  fill_fifo_empty_i, fill_fifo_data_i, awready_i, wready_i,
               bid_i, bresp_i, bvalid_i,
        output fill_fifo_rden_o, awid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
               awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
               busy_o, err_o
    );

    modport slave (
        output fill_fifo_empty_i, fill_fifo_data_i, awready_i, wready_i,
               bid_i, bresp_i, bvalid_i,
        input  fill_fifo_rden_o, awid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
               awvalid_o, wdata_o, wstrb_o, wlast_o, wvalid_o, bready_o,
               busy_o, err_o
    );
endinterface

// File: rtl/fill_drain.sv
// fill_drain: pops one {address, line} entry from the Fill FIFO and issues it as a
// single-beat AXI4 write, one write outstanding. Define FILL_DRAIN_BRESP_CHK_EN to flag bad BRESP/BID.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif

module fill_drain #(
    parameter int                  ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int                  DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int                  ID_WIDTH   = `AXI_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID         = `AXI_ID
) (
    input  logic         clk,
    input  logic         rst,
    fill_drain_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_REQ, S_RESP} state_t;

    state_t                state;
    state_t                next_state;
    logic                  aw_done;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] line_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;

    assign aw_hs = bus.awvalid_o & bus.awready_i;
    assign w_hs  = bus.wvalid_o  & bus.wready_i;
    assign b_hs  = bus.bvalid_i  & bus.bready_o;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (!bus.fill_fifo_empty_i) next_state = S_POP;
            S_POP:   next_state = S_LOAD;
            S_LOAD:  next_state = S_REQ;
            S_REQ:   if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = S_RESP;
            S_RESP:  if (b_hs) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fill_fifo_rden_o = 1'b0;
        bus.awvalid_o        = 1'b0;
        bus.wvalid_o         = 1'b0;
        bus.bready_o         = 1'b0;
        bus.busy_o           = (state != S_IDLE);
        unique case (state)
            S_POP:  bus.fill_fifo_rden_o = 1'b1;
            S_REQ: begin
                bus.awvalid_o = !aw_done;
                bus.wvalid_o  = !w_done;
            end
            S_RESP: bus.bready_o = 1'b1;
            default: ;
        endcase
    end

    // AW and W complete independently; each flag retires its own valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == S_REQ) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end
    end

    // FIFO read data is valid in S_LOAD (one-cycle read latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            line_q <= '0;
        end else if (state == S_LOAD) begin
            addr_q <= bus.fill_fifo_data_i[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
            line_q <= bus.fill_fifo_data_i[DATA_WIDTH-1:0];
        end
    end

    assign bus.awid_o    = ID;
    assign bus.awaddr_o  = addr_q;
    assign bus.awlen_o   = 8'd0;
    assign bus.awsize_o  = 3'($clog2(DATA_WIDTH / 8));
    assign bus.awburst_o = 2'b01;
    assign bus.wdata_o   = line_q;
    assign bus.wstrb_o   = '1;
    assign bus.wlast_o   = 1'b1;

`ifdef FILL_DRAIN_BRESP_CHK_EN
    logic       err_q;
    logic [7:0] err_cnt;
    logic       bad_b;

    assign bad_b = b_hs && ((bus.bresp_i != 2'b00) || (bus.bid_i != ID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q   <= 1'b0;
            err_cnt <= 8'd0;
        end else if (bad_b) begin
            err_q <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.err_o = err_q;
`else
    logic unused_b;
    assign unused_b  = ^{bus.bid_i, bus.bresp_i};
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_fill_drain.sv
// Self-checking bench for fill_drain: event-level model of the drain sequence, FIFO emulation,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fill_drain;
    localparam int             AW = 32;
    localparam int             DW = 64;
    localparam int             IW = 4;
    localparam logic [IW-1:0]  ID = 4'h5;
`ifdef FILL_DRAIN_BRESP_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    fill_drain_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    fill_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ID(ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO contents and the entry currently being written
    logic [AW+DW-1:0] fifo_q[$];
    logic [AW-1:0]    cur_addr;
    logic [DW-1:0]    cur_line;

    // model of the transaction in flight: age = cycles since the pop strobe
    bit m_active, m_aw_ok, m_w_ok, m_b_pend, m_err;
    int m_age, m_err_cnt;

    // observation counters
    int cyc = 0, last_rden = -1, last_gap = 0;
    int n_rden = 0, n_awv = 0, n_wv = 0, n_bready = 0, n_b_hs = 0;

    // stimulus knobs
    int aw_stall = 0, w_stall = 0, b_stall = 0;
    int bad_resp_at = -1;
    int p_rdy = 100, push_pct = 0, to_push = 0;
    bit rand_bad = 0, hold_empty = 0;

    task automatic model_reset();
        m_active = 0; m_aw_ok = 0; m_w_ok = 0; m_b_pend = 0;
        m_err = 0; m_age = 0; m_err_cnt = 0;
    endtask

    task automatic step();
        bit e_rden, e_awv, e_wv, awr, wr, bv, bad;
        logic [1:0]       br;
        logic [IW-1:0]    bi;
        logic [AW+DW-1:0] ent;
        @(negedge clk);
        cyc++;
        e_rden = m_active && (m_age == 0);
        e_awv  = m_active && (m_age >= 2) && !m_aw_ok;
        e_wv   = m_active && (m_age >= 2) && !m_w_ok;

        check("rden", bus.fill_fifo_rden_o, e_rden);
        check("busy", bus.busy_o, m_active);
        check("awvalid", bus.awvalid_o, e_awv);
        check("wvalid", bus.wvalid_o, e_wv);
        check("bready", bus.bready_o, m_b_pend);
        check("err", bus.err_o, m_err);
        if (e_awv) check("awaddr", bus.awaddr_o, cur_addr);
        if (e_wv)  check("wdata", bus.wdata_o, cur_line);
        check("awlen", bus.awlen_o, 8'd0);
        check("awsize", bus.awsize_o, 3'd3);
        check("awburst", bus.awburst_o, 2'b01);
        check("awid", bus.awid_o, ID);
        check("wstrb", bus.wstrb_o, 8'hFF);
        check("wlast", bus.wlast_o, 1'b1);
`ifdef FILL_DRAIN_BRESP_CHK_EN
        check("err_cnt", dut.err_cnt, m_err_cnt);
`endif
        if (bus.fill_fifo_rden_o) begin
            if (last_rden >= 0) begin
                last_gap = cyc - last_rden;
                check("rden_gap_ge5", last_gap >= 5, 1'b1);
            end
            last_rden = cyc;
            n_rden++;
        end
        if (bus.awvalid_o) n_awv++;
        if (bus.wvalid_o)  n_wv++;
        if (bus.bready_o)  n_bready++;

        awr = ($urandom_range(99) < p_rdy);
        wr  = ($urandom_range(99) < p_rdy);
        bv  = ($urandom_range(99) < p_rdy);
        if (bus.awvalid_o && aw_stall > 0) begin awr = 0; aw_stall--; end
        if (bus.wvalid_o && w_stall > 0)   begin wr = 0;  w_stall--;  end
        if (bus.bready_o && b_stall > 0)   begin bv = 0;  b_stall--;  end
        br = 2'b00;
        bi = ID;
        if (m_b_pend && bv && n_b_hs == bad_resp_at) br = 2'b10;
        if (rand_bad && $urandom_range(9) == 0) begin
            if ($urandom_range(1) == 0) br = 2'($urandom_range(3, 1));
            else                        bi = ID ^ 4'h1;
        end
        bus.awready_i = awr;
        bus.wready_i  = wr;
        bus.bvalid_i  = bv;
        bus.bresp_i   = br;
        bus.bid_i     = bi;

        // the pop commits at the coming edge; FIFO data follows one cycle later
        if (e_rden && fifo_q.size() > 0) begin
            ent = fifo_q.pop_front();
            bus.fill_fifo_data_i = ent;
            cur_addr = ent[AW+DW-1:DW];
            cur_line = ent[DW-1:0];
        end
        if (to_push > 0 && $urandom_range(99) < push_pct) begin
            ent = {$urandom(), $urandom(), $urandom()};
            fifo_q.push_back(ent);
            to_push--;
        end
        bus.fill_fifo_empty_i = hold_empty || (fifo_q.size() == 0);

        if (!m_active) begin
            if (!bus.fill_fifo_empty_i) begin
                m_active = 1;
                m_age = 0;
            end
        end else if (m_b_pend && bv) begin
            bad = (br != 2'b00) || (bi != ID);
            if (CHK && bad) begin
                m_err = 1;
                if (m_err_cnt < 255) m_err_cnt++;
            end
            n_b_hs++;
            m_active = 0; m_aw_ok = 0; m_w_ok = 0; m_b_pend = 0;
        end else begin
            if (e_awv && awr) m_aw_ok = 1;
            if (e_wv && wr)   m_w_ok = 1;
            if (m_aw_ok && m_w_ok) m_b_pend = 1;
            m_age++;
        end
    endtask

    task automatic run_until_drained(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((to_push > 0 || fifo_q.size() > 0 || m_active) && n < budget);
        check({name, "_drained"}, n < budget, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, r0, n;
        bit s1, s2;

        bus.fill_fifo_empty_i = 1'b1;
        bus.fill_fifo_data_i  = '0;
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b0;
        bus.bvalid_i  = 1'b0;
        bus.bresp_i   = 2'b00;
        bus.bid_i     = ID;
        model_reset();

        // reset values
        #1;
        check("rst_rden", bus.fill_fifo_rden_o, 1'b0);
        check("rst_awvalid", bus.awvalid_o, 1'b0);
        check("rst_wvalid", bus.wvalid_o, 1'b0);
        check("rst_bready", bus.bready_o, 1'b0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_err", bus.err_o, 1'b0);
        check("rst_awaddr", bus.awaddr_o, 32'h0);
        check("rst_wdata", bus.wdata_o, 64'h0);
        check("rst_awsize", bus.awsize_o, 3'd3);
        check("rst_wstrb", bus.wstrb_o, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single entry, everything ready: T0 idle, T1 pop, T3 request, T4 response, T5 idle
        fifo_q.push_back({32'h0000_1000, {8{8'hA5}}});
        r0 = n_rden;
        step();
        check("single_t0_busy", bus.busy_o, 1'b0);
        step();
        check("single_t1_rden", bus.fill_fifo_rden_o, 1'b1);
        step();
        check("single_t2_awvalid", bus.awvalid_o, 1'b0);
        step();
        check("single_t3_awvalid", bus.awvalid_o, 1'b1);
        check("single_t3_awaddr", bus.awaddr_o, 32'h0000_1000);
        check("single_t3_wdata", bus.wdata_o, 64'hA5A5_A5A5_A5A5_A5A5);
        check("single_t3_wlast", bus.wlast_o, 1'b1);
        step();
        check("single_t4_bready", bus.bready_o, 1'b1);
        step();
        check("single_t5_busy", bus.busy_o, 1'b0);
        check("single_one_pop", n_rden - r0, 1);

        // channel skew: AW stalled four cycles, W accepted at once
        fifo_q.push_back({32'h0000_2040, 64'h0123_4567_89AB_CDEF});
        base = n_awv; r0 = n_wv; n = n_bready;
        aw_stall = 4;
        run_until_drained("skew", 100);
        check("skew_awvalid_cycles", n_awv - base, 5);
        check("skew_wvalid_cycles", n_wv - r0, 1);
        check("skew_bready_cycles", n_bready - n, 1);

        // back-to-back: three entries in FIFO order
        for (int i = 0; i < 3; i++)
            fifo_q.push_back({32'h0000_3000 + 32'(i * 64), {2{32'hC0DE_0000 + 32'(i)}}});
        base = n_b_hs; r0 = n_rden;
        run_until_drained("b2b", 200);
        check("b2b_pops", n_rden - r0, 3);
        check("b2b_writes", n_b_hs - base, 3);
        check("b2b_min_gap", last_gap, 5);

        // response stall: bvalid withheld for ten cycles
        fifo_q.push_back({32'h0000_4000, 64'hFEED_FACE_DEAD_BEEF});
        n = n_bready; r0 = n_rden;
        b_stall = 10;
        run_until_drained("stall", 100);
        check("stall_bready_cycles", n_bready - n, 11);
        check("stall_one_pop", n_rden - r0, 1);

        // error response on the second of three writes
        for (int i = 0; i < 3; i++)
            fifo_q.push_back({32'h0000_5000 + 32'(i * 64), {2{32'hE000_0000 + 32'(i)}}});
        base = n_b_hs;
        bad_resp_at = base + 1;
        s1 = 0; s2 = 0; n = 0;
        while ((fifo_q.size() > 0 || m_active) && n < 300) begin
            step(); n++;
            if (!s1 && n_b_hs - base == 1) begin
                step(); n++;
                check("err_after_1st", bus.err_o, 1'b0);
                s1 = 1;
            end
            if (!s2 && n_b_hs - base == 2) begin
                step(); n++;
                check("err_after_2nd", bus.err_o, CHK);
                s2 = 1;
            end
        end
        bad_resp_at = -1;
        check("err_third_done", n_b_hs - base, 3);
        check("err_sticky", bus.err_o, CHK);

        // reset while awvalid is high: in-flight entry is dropped
        fifo_q.push_back({32'h0000_6000, 64'h1111_2222_3333_4444});
        fifo_q.push_back({32'h0000_6040, 64'h5555_6666_7777_8888});
        aw_stall = 3;
        n = 0;
        do begin step(); n++; end while (!bus.awvalid_o && n < 50);
        check("rstmid_saw_awvalid", bus.awvalid_o, 1'b1);
        #2;
        rst = 1'b1;
        hold_empty = 1;
        bus.fill_fifo_empty_i = 1'b1;
        #1;
        check("rstmid_awvalid", bus.awvalid_o, 1'b0);
        check("rstmid_wvalid", bus.wvalid_o, 1'b0);
        check("rstmid_bready", bus.bready_o, 1'b0);
        check("rstmid_busy", bus.busy_o, 1'b0);
        check("rstmid_rden", bus.fill_fifo_rden_o, 1'b0);
        check("rstmid_err", bus.err_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        aw_stall = 0;
        model_reset();
        r0 = n_rden;
        repeat (6) step();
        check("rstmid_idle_busy", bus.busy_o, 1'b0);
        check("rstmid_no_pop", n_rden - r0, 0);
        hold_empty = 0;
        base = n_b_hs;
        run_until_drained("after_rst", 100);
        check("after_rst_writes", n_b_hs - base, 1);

        // randomized soak
        p_rdy = 60; push_pct = 30; to_push = 40; rand_bad = 1;
        base = n_b_hs;
        run_until_drained("random", 20000);
        check("random_writes", n_b_hs - base, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
